results_loader: RTL and testbench

- Receive direction of the 32-bit CPU bus interface: accepts the problem-description stream from the CPU and writes it into the shared solver RAM.
- Assembles DATA_WIDTH-bit words from 32-bit beats, sending the low half first.
- Fills the same RAM map that the results path later reads back: T count, X count, T values and the initial X vector.
- Sits between the CPU bus and RAM port A, ahead of the solver core.

---
 rtl/results_loader_pkg.sv | 24 ++
 rtl/results_loader_if.sv | 12 +
 rtl/results_loader_word_packer.sv | 50 +++++
 rtl/results_loader.sv | 178 +++++++++++++++++
 tb/tb_results_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/results_loader_pkg.sv
// Shared constants and state type for the CPU-to-RAM loader and the results sender.
// Both sides use the same RAM map: counts at 1 and 2, T values from 3, X vector from 10.
package results_loader_pkg;

  localparam int NUMBER_OF_T_ADDRESS   = 1;
  localparam int NUMBER_OF_X_ADDRESS   = 2;
  localparam int STARTING_OF_T_ADDRESS = 3;
  localparam int STARTING_OF_X_ADDRESS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_T,
    ST_HDR_X,
    ST_LOAD_T,
    ST_LOAD_X,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  function automatic int beats_for(input int data_width);
    return data_width / 32;
  endfunction

endpackage

// File: rtl/results_loader_if.sv
// 32-bit CPU bus beat channel with a valid/ready handshake.
// The CPU side is the master; the loader is the slave.
interface results_loader_if;

  logic [31:0] CPU_Bus;
  logic        CPU_Valid;
  logic        Loader_Ready;

  modport master (output CPU_Bus, output CPU_Valid, input Loader_Ready);
  modport slave  (input CPU_Bus, input CPU_Valid, output Loader_Ready);

endinterface

// File: rtl/results_loader_word_packer.sv
// Builds RAM words from 32-bit beats, low half first.
// word and word_valid are combinational on the completing transfer, so the caller can register the write.
module word_packer
  import results_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           beat,
  input  logic                  xfer,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid
);

  if (beats_for(DATA_WIDTH) == 1) begin : g_single
    assign word       = beat;
    assign word_valid = xfer;
  end else begin : g_pair
    logic        phase_q, phase_d;
    logic [31:0] low_q, low_d;

    always_ff @(posedge CLK) begin
      if (RST) begin
        phase_q <= 1'b0;
        low_q   <= '0;
      end else begin
        phase_q <= phase_d;
        low_q   <= low_d;
      end
    end

    // Clear wins over a simultaneous transfer so an aborted load leaves no stale half.
    always_comb begin
      phase_d = phase_q;
      low_d   = low_q;
      if (clear) begin
        phase_d = 1'b0;
      end else if (xfer) begin
        phase_d = ~phase_q;
        if (!phase_q) low_d = beat;
      end
    end

    assign word       = {beat, low_q};
    assign word_valid = xfer && phase_q && !clear;
  end

endmodule

// File: rtl/results_loader.sv
// Receives the problem description from the CPU bus and writes it into solver RAM port A.
// Header counts go to fixed addresses, then T words and X words are written in stream order.
module results_loader
  import results_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_T         = 7,
  parameter int MAX_X         = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Load_Enable,
  results_loader_if.slave          cpu,
  output logic                     RAM_Write_Enable,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address,
  output logic [DATA_WIDTH-1:0]    RAM_Data,
  output logic                     Done_Loading,
  output logic                     Load_Error
);

  loader_state_e state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] num_t_q, num_t_d;
  logic [ADDRESS_WIDTH-1:0] num_x_q, num_x_d;
  logic [ADDRESS_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic                     t_bad_q, t_bad_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;

  logic                     xfer;
  logic                     in_load;
  logic                     active;
  logic [ADDRESS_WIDTH-1:0] hdr_val;
  logic                     hdr_high;
  logic [DATA_WIDTH-1:0]    hdr_word;
  logic [DATA_WIDTH-1:0]    packed_word;
  logic                     packed_valid;

  assign active   = state_q inside {ST_HDR_T, ST_HDR_X, ST_LOAD_T, ST_LOAD_X};
  assign in_load  = state_q inside {ST_LOAD_T, ST_LOAD_X};
  assign cpu.Loader_Ready = active;
  assign xfer     = cpu.CPU_Valid && active;
  assign hdr_val  = cpu.CPU_Bus[ADDRESS_WIDTH-1:0];
  assign hdr_high = |cpu.CPU_Bus[31:ADDRESS_WIDTH];

  always_comb begin
    hdr_word       = '0;
    hdr_word[31:0] = cpu.CPU_Bus;
  end

  word_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .CLK        (CLK),
    .RST        (RST),
    .beat       (cpu.CPU_Bus),
    .xfer       (xfer && in_load),
    .clear      (!in_load || !Load_Enable),
    .word       (packed_word),
    .word_valid (packed_valid)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      num_t_q    <= '0;
      num_x_q    <= '0;
      word_cnt_q <= '0;
      t_bad_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_t_q    <= num_t_d;
      num_x_q    <= num_x_d;
      word_cnt_q <= word_cnt_d;
      t_bad_q    <= t_bad_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Dropping Load_Enable in any active state abandons the load without a further write.
  always_comb begin
    state_d    = state_q;
    num_t_d    = num_t_q;
    num_x_d    = num_x_q;
    word_cnt_d = word_cnt_q;
    t_bad_d    = t_bad_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (active && !Load_Enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          word_cnt_d = '0;
          if (Load_Enable && !done_q) state_d = ST_HDR_T;
        end
        ST_HDR_T: begin
          if (xfer) begin
            num_t_d   = hdr_val;
            t_bad_d   = hdr_high || (hdr_val > ADDRESS_WIDTH'(MAX_T));
            wr_en_d   = 1'b1;
            wr_addr_d = ADDRESS_WIDTH'(NUMBER_OF_T_ADDRESS);
            wr_data_d = hdr_word;
            state_d   = ST_HDR_X;
          end
        end
        ST_HDR_X: begin
          if (xfer) begin
            num_x_d    = hdr_val;
            word_cnt_d = '0;
            wr_en_d    = 1'b1;
            wr_addr_d  = ADDRESS_WIDTH'(NUMBER_OF_X_ADDRESS);
            wr_data_d  = hdr_word;
            if (t_bad_q || hdr_high || (hdr_val > ADDRESS_WIDTH'(MAX_X)) || (hdr_val == '0))
              state_d = ST_ERROR;
            else if (num_t_q == '0)
              state_d = ST_LOAD_X;
            else
              state_d = ST_LOAD_T;
          end
        end
        ST_LOAD_T: begin
          if (packed_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDRESS_WIDTH'(STARTING_OF_T_ADDRESS) + word_cnt_q;
            wr_data_d = packed_word;
            if (word_cnt_q == num_t_q - ADDRESS_WIDTH'(1)) begin
              word_cnt_d = '0;
              state_d    = ST_LOAD_X;
            end else begin
              word_cnt_d = word_cnt_q + ADDRESS_WIDTH'(1);
            end
          end
        end
        ST_LOAD_X: begin
          if (packed_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDRESS_WIDTH'(STARTING_OF_X_ADDRESS) + word_cnt_q;
            wr_data_d = packed_word;
            if (word_cnt_q == num_x_q - ADDRESS_WIDTH'(1)) begin
              word_cnt_d = '0;
              state_d    = ST_DONE;
            end else begin
              word_cnt_d = word_cnt_q + ADDRESS_WIDTH'(1);
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          if (!Load_Enable) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Flags rise one cycle after entering DONE/ERROR, i.e. after the last write strobe.
  assign done_d  = (state_q inside {ST_DONE, ST_ERROR}) && (state_d == state_q);
  assign error_d = (state_q == ST_ERROR) && (state_d == ST_ERROR);

  assign RAM_Write_Enable = wr_en_q;
  assign RAM_Address      = wr_addr_q;
  assign RAM_Data         = wr_data_q;
  assign Done_Loading     = done_q;
  assign Load_Error       = error_q;

endmodule

// File: tb/tb_results_loader.sv
// Self-checking bench for results_loader: a transaction-level model predicts the RAM write list
// for each stream, and a per-cycle compare process checks every strobe against it.
module tb_results_loader;

  localparam int AW = 13;
  localparam int DW = 64;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Load_Enable;
  logic          RAM_Write_Enable;
  logic [AW-1:0] RAM_Address;
  logic [DW-1:0] RAM_Data;
  logic          Done_Loading;
  logic          Load_Error;

  results_loader_if bus ();

  results_loader #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_T(7), .MAX_X(64)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .Load_Enable      (Load_Enable),
    .cpu              (bus),
    .RAM_Write_Enable (RAM_Write_Enable),
    .RAM_Address      (RAM_Address),
    .RAM_Data         (RAM_Data),
    .Done_Loading     (Done_Loading),
    .Load_Error       (Load_Error)
  );

  always #5 CLK = ~CLK;

  int      errors = 0;
  int      checks = 0;
  longint  cyc = 0;
  longint  last_wr_cyc = -10;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] act_addr[$];
  logic [DW-1:0] act_data[$];
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  logic [63:0] t_words[8];
  logic [63:0] x_words[64];

  always @(posedge CLK) cyc <= cyc + 1;

  // Per-cycle compare against the predicted write list plus flag invariants.
  always @(negedge CLK) begin
    if (!RST) begin
      checks++;
      if (bus.Loader_Ready && Done_Loading) begin
        errors++;
        $display("[TB] FAIL ready_while_done actual ready=%0b done=%0b required ready=0", bus.Loader_Ready, Done_Loading);
      end
      checks++;
      if (Load_Error && !Done_Loading) begin
        errors++;
        $display("[TB] FAIL error_without_done actual done=%0b required done=1", Done_Loading);
      end
      if (RAM_Write_Enable) begin
        act_addr.push_back(RAM_Address);
        act_data.push_back(RAM_Data);
        last_wr_cyc = cyc;
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write actual addr=%0d data=%h required no write", RAM_Address, RAM_Data);
        end else begin
          e_addr = exp_addr_q.pop_front();
          e_data = exp_data_q.pop_front();
          if (RAM_Address !== e_addr || RAM_Data !== e_data) begin
            errors++;
            $display("[TB] FAIL write actual addr=%0d data=%h required addr=%0d data=%h", RAM_Address, RAM_Data, e_addr, e_data);
          end
        end
      end
    end
  end

  function automatic bit headerBad(input logic [31:0] t_hdr, input logic [31:0] x_hdr);
    return (t_hdr > 7) || (x_hdr > 64) || (x_hdr == 0);
  endfunction

  task automatic expectWrite(input int addr, input logic [63:0] data);
    exp_addr_q.push_back(AW'(addr));
    exp_data_q.push_back(data);
  endtask

  task automatic buildExpected(input logic [31:0] t_hdr, input logic [31:0] x_hdr);
    expectWrite(1, {32'h0, t_hdr});
    expectWrite(2, {32'h0, x_hdr});
    if (!headerBad(t_hdr, x_hdr)) begin
      for (int i = 0; i < int'(t_hdr); i++) expectWrite(3 + i, t_words[i]);
      for (int j = 0; j < int'(x_hdr); j++) expectWrite(10 + j, x_words[j]);
    end
  endtask

  task automatic sendBeat(input logic [31:0] data, input int gap);
    bit got;
    for (int g = 0; g < gap; g++) begin
      bus.CPU_Valid = 1'b0;
      bus.CPU_Bus   = $urandom;
      @(posedge CLK); #1;
    end
    bus.CPU_Valid = 1'b1;
    bus.CPU_Bus   = data;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge CLK);
      if (bus.Loader_Ready) got = 1'b1;
    end
    @(posedge CLK); #1;
    bus.CPU_Valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_accept_timeout actual ready=0 required ready=1 within 50 cycles");
    end
  endtask

  function automatic int pickGap(input int gap_max);
    return (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
  endfunction

  // Drives one full stream; hold_gap >= 0 forces that many idle cycles before the hi half of T word 1.
  task automatic applyStimulus(input logic [31:0] t_hdr, input logic [31:0] x_hdr,
                               input int gap_max, input int hold_gap);
    buildExpected(t_hdr, x_hdr);
    Load_Enable = 1'b1;
    sendBeat(t_hdr, pickGap(gap_max));
    sendBeat(x_hdr, pickGap(gap_max));
    if (!headerBad(t_hdr, x_hdr)) begin
      for (int i = 0; i < int'(t_hdr); i++) begin
        sendBeat(t_words[i][31:0], pickGap(gap_max));
        sendBeat(t_words[i][63:32], (i == 1 && hold_gap >= 0) ? hold_gap : pickGap(gap_max));
      end
      for (int j = 0; j < int'(x_hdr); j++) begin
        sendBeat(x_words[j][31:0], pickGap(gap_max));
        sendBeat(x_words[j][63:32], pickGap(gap_max));
      end
    end
  endtask

  task automatic checkOutput(input bit exp_err);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge CLK);
      if (Done_Loading) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL done_timeout actual done=0 required done=1 within 60 cycles");
    end else if (cyc != last_wr_cyc + 1) begin
      errors++;
      $display("[TB] FAIL done_timing actual cycle=%0d required cycle=%0d", cyc, last_wr_cyc + 1);
    end
    checks++;
    if (Load_Error !== exp_err) begin
      errors++;
      $display("[TB] FAIL load_error actual=%0b required=%0b", Load_Error, exp_err);
    end
    checks++;
    if (bus.Loader_Ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_in_done actual=%0b required=0", bus.Loader_Ready);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_writes actual pending=%0d required pending=0", exp_addr_q.size());
    end
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge CLK); #1;
    Load_Enable = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (Done_Loading !== 1'b0 || Load_Error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flags_clear actual done=%0b error=%0b required done=0 error=0", Done_Loading, Load_Error);
    end
    @(posedge CLK); #1;
  endtask

  task automatic checkReset(input string tag);
    checks++;
    if (RAM_Write_Enable !== 1'b0 || RAM_Address !== '0 || RAM_Data !== '0 ||
        Done_Loading !== 1'b0 || Load_Error !== 1'b0 || bus.Loader_Ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s actual we=%0b addr=%0d data=%h done=%0b err=%0b ready=%0b required all 0",
               tag, RAM_Write_Enable, RAM_Address, RAM_Data, Done_Loading, Load_Error, bus.Loader_Ready);
    end
  endtask

  task automatic checkLiteral(input string tag, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", tag, actual, required);
    end
  endtask

  task automatic randomWords();
    for (int i = 0; i < 8; i++) t_words[i] = {$urandom, $urandom};
    for (int j = 0; j < 64; j++) x_words[j] = {$urandom, $urandom};
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] t_hdr, x_hdr;
    RST = 1'b1;
    Load_Enable = 1'b0;
    bus.CPU_Valid = 1'b0;
    bus.CPU_Bus = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkReset("reset_state");
    @(posedge CLK); #1;
    RST = 1'b0;

    // Continuous two-T, three-X stream with literal expectations on the captured writes.
    t_words[0] = 64'h1111_2222_3333_4444;
    t_words[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    x_words[0] = 64'h0000_0001_0000_0002;
    x_words[1] = 64'h0000_0003_0000_0004;
    x_words[2] = 64'h0000_0005_0000_0006;
    act_addr.delete(); act_data.delete();
    applyStimulus(32'd2, 32'd3, 0, -1);
    checkOutput(1'b0);
    checkLiteral("write_count", 64'(act_addr.size()), 64'd7);
    if (act_addr.size() == 7) begin
      checkLiteral("addr_t_count", 64'(act_addr[0]), 64'd1);
      checkLiteral("data_t_count", act_data[0], 64'd2);
      checkLiteral("data_x_count", act_data[1], 64'd3);
      checkLiteral("addr_t1", 64'(act_addr[3]), 64'd4);
      checkLiteral("data_t0", act_data[2], 64'h1111_2222_3333_4444);
      checkLiteral("addr_x2", 64'(act_addr[6]), 64'd12);
      checkLiteral("data_x2", act_data[6], 64'h0000_0005_0000_0006);
    end

    // Same stream with a three-cycle hole between the halves of T word 1.
    act_addr.delete(); act_data.delete();
    applyStimulus(32'd2, 32'd3, 0, 3);
    checkOutput(1'b0);
    checkLiteral("gap_write_count", 64'(act_addr.size()), 64'd7);
    if (act_addr.size() == 7)
      checkLiteral("gap_data_t1", act_data[3], 64'hAAAA_BBBB_CCCC_DDDD);

    // Out-of-range T count.
    applyStimulus(32'd8, 32'd3, 0, -1);
    checkOutput(1'b1);

    // Zero T values.
    randomWords();
    act_addr.delete(); act_data.delete();
    applyStimulus(32'd0, 32'd2, 1, -1);
    checkOutput(1'b0);
    if (act_addr.size() == 4)
      checkLiteral("t0_first_x_addr", 64'(act_addr[2]), 64'd10);
    else
      checkLiteral("t0_write_count", 64'(act_addr.size()), 64'd4);

    // Abort after the first T word, then a fresh 1,1 load.
    randomWords();
    expectWrite(1, 64'd2);
    expectWrite(2, 64'd3);
    expectWrite(3, t_words[0]);
    Load_Enable = 1'b1;
    sendBeat(32'd2, 0);
    sendBeat(32'd3, 0);
    sendBeat(t_words[0][31:0], 0);
    sendBeat(t_words[0][63:32], 0);
    Load_Enable = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (bus.Loader_Ready !== 1'b0 || Done_Loading !== 1'b0 || exp_addr_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL abort actual ready=%0b done=%0b pending=%0d required 0 0 0",
               bus.Loader_Ready, Done_Loading, exp_addr_q.size());
    end
    exp_addr_q.delete(); exp_data_q.delete();
    @(posedge CLK); #1;
    randomWords();
    applyStimulus(32'd1, 32'd1, 1, -1);
    checkOutput(1'b0);

    // Reset while the hi half of a T word is pending.
    expectWrite(1, 64'd1);
    expectWrite(2, 64'd1);
    Load_Enable = 1'b1;
    sendBeat(32'd1, 0);
    sendBeat(32'd1, 0);
    sendBeat(32'hDEAD_BEEF, 0);
    RST = 1'b1;
    Load_Enable = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checkReset("reset_mid_load");
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL header_writes_before_reset actual pending=%0d required pending=0", exp_addr_q.size());
    end
    exp_addr_q.delete(); exp_data_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    randomWords();
    applyStimulus(32'd1, 32'd1, 0, -1);
    checkOutput(1'b0);

    // Randomized legal loads with random idle gaps.
    for (int r = 0; r < 8; r++) begin
      randomWords();
      t_hdr = $urandom_range(0, 7);
      x_hdr = $urandom_range(1, 6);
      applyStimulus(t_hdr, x_hdr, 2, -1);
      checkOutput(1'b0);
    end

    // Randomized illegal headers of every kind.
    for (int r = 0; r < 8; r++) begin
      case (r % 4)
        0: begin t_hdr = $urandom_range(8, 40); x_hdr = $urandom_range(1, 64); end
        1: begin t_hdr = $urandom_range(0, 7);  x_hdr = 32'd0; end
        2: begin t_hdr = $urandom_range(0, 7);  x_hdr = $urandom_range(65, 200); end
        default: begin t_hdr = 32'h0001_0000 | $urandom_range(0, 7); x_hdr = $urandom_range(1, 64); end
      endcase
      applyStimulus(t_hdr, x_hdr, 1, -1);
      checkOutput(1'b1);
    end

    // Largest legal X count reaches the top of the X region.
    randomWords();
    act_addr.delete(); act_data.delete();
    applyStimulus(32'd7, 32'd64, 0, -1);
    checkOutput(1'b0);
    if (act_addr.size() == 73)
      checkLiteral("max_x_last_addr", 64'(act_addr[72]), 64'd73);
    else
      checkLiteral("max_write_count", 64'(act_addr.size()), 64'd73);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
